jt6295_voice_ctrl: RTL and testbench

//  Sequences the four time-multiplexed voices into the shared jt6295_adpcm pipeline.
//  - Holds per-voice start/end/attenuation state.
//  - Fetches sample bytes from ROM through a round-robin fetcher.
//  - On each cen presents one voice slot (en, att, nibble) to the ADPCM datapath, in fixed voice order 0,1,2,3.

---
 rtl/jt6295_voice_ctrl_pkg.sv | 29 ++
 rtl/jt6295_voice_ctrl_rom_fetch.sv | 69 ++++++
 rtl/jt6295_voice_ctrl.sv | 148 ++++++++++++++
 tb/tb_jt6295_voice_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt6295_voice_ctrl_pkg.sv
// rtl/jt6295_voice_ctrl_pkg.sv - shared constants, slot output type and round-robin helper
package jt6295_voice_ctrl_pkg;

    // Four voices, locked to the four pipeline stages of the ADPCM datapath
    localparam int NV = 4;

    // Fetch FSM state encodings
    localparam logic [0:0] FS_IDLE = 1'b0;
    localparam logic [0:0] FS_WAIT = 1'b1;

    typedef struct packed {
        logic       en;
        logic [3:0] att;
        logic [3:0] data;
    } adpcm_slot_t;

    // Returns {found, voice}: first requesting voice at or after ptr, wrapping
    function automatic logic [2:0] rr_pick(input logic [NV-1:0] req, input logic [1:0] ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = NV - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

endpackage

// File: rtl/jt6295_voice_ctrl_rom_fetch.sv
// rtl/jt6295_voice_ctrl_rom_fetch.sv - round-robin ROM byte fetcher with qualified acknowledge
module jt6295_voice_ctrl_rom_fetch
    import jt6295_voice_ctrl_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [NV-1:0]  i_req,
    input  logic [NV*AW-1:0] i_addr,
    input  logic [7:0]     i_rom_data,
    input  logic           i_rom_ok,
    output logic [AW-1:0]  o_rom_addr,
    output logic           o_rom_cs,
    output logic           o_issue,
    output logic [1:0]     o_issue_voice,
    output logic           o_done,
    output logic [1:0]     o_voice,
    output logic [7:0]     o_byte
);

    logic [0:0]    r_state;
    logic [1:0]    r_rr;
    logic [1:0]    r_voice;
    logic          r_armed;
    logic          r_cs;
    logic [AW-1:0] r_addr;
    logic [2:0]    w_pick;

    assign w_pick        = rr_pick(i_req, r_rr);
    assign o_issue       = (r_state == FS_IDLE) && w_pick[2];
    assign o_issue_voice = w_pick[1:0];
    // The first WAIT clock never accepts: an ok still high from the previous
    // transfer would otherwise latch a byte for the wrong address
    assign o_done        = (r_state == FS_WAIT) && r_armed && i_rom_ok;
    assign o_voice       = r_voice;
    assign o_byte        = i_rom_data;
    assign o_rom_addr    = r_addr;
    assign o_rom_cs      = r_cs;

    // IDLE/WAIT sequencing: issue one request, hold it until a qualified ok
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FS_IDLE;
            r_rr    <= 2'd0;
            r_voice <= 2'd0;
            r_armed <= 1'b0;
            r_cs    <= 1'b0;
            r_addr  <= '0;
        end else if (r_state == FS_IDLE) begin
            if (w_pick[2]) begin
                r_addr  <= i_addr[w_pick[1:0]*AW +: AW];
                r_voice <= w_pick[1:0];
                r_cs    <= 1'b1;
                r_armed <= 1'b0;
                r_state <= FS_WAIT;
            end
        end else begin
            if (!r_armed) begin
                r_armed <= 1'b1;
            end else if (i_rom_ok) begin
                r_cs    <= 1'b0;
                r_rr    <= r_voice + 2'd1;
                r_state <= FS_IDLE;
            end
        end
    end

endmodule

// File: rtl/jt6295_voice_ctrl.sv
// rtl/jt6295_voice_ctrl.sv - four-voice slot sequencer feeding the shared ADPCM pipeline
module jt6295_voice_ctrl
    import jt6295_voice_ctrl_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cen,
    input  logic          i_cmd_we,
    input  logic          i_cmd_stop,
    input  logic [1:0]    i_cmd_ch,
    input  logic [AW-1:0] i_cmd_start,
    input  logic [AW-1:0] i_cmd_end,
    input  logic [3:0]    i_cmd_att,
    output logic [3:0]    o_busy,
    output logic [3:0]    o_underrun,
    output logic [AW-1:0] o_rom_addr,
    output logic          o_rom_cs,
    input  logic [7:0]    i_rom_data,
    input  logic          i_rom_ok,
    output logic          o_adpcm_en,
    output logic [3:0]    o_adpcm_att,
    output logic [3:0]    o_adpcm_data,
    output logic [1:0]    o_slot
);

    logic [AW:0]     r_na  [NV];
    logic [AW-1:0]   r_end [NV];
    logic [3:0]      r_att [NV];
    logic [7:0]      r_buf [NV];
    logic [NV-1:0]   r_bv;
    logic [NV-1:0]   r_busy;
    logic [NV-1:0]   r_under;
    logic            r_stale;
    logic [1:0]      r_slot;
    adpcm_slot_t     r_out;

    logic [1:0]      w_nslot;
    logic [NV*AW-1:0] w_addr_flat;
    logic            w_cmd_eff;
    logic            w_issue;
    logic [1:0]      w_issue_voice;
    logic            w_done;
    logic [1:0]      w_fvoice;
    logic [7:0]      w_byte;

    assign w_nslot   = r_slot + 2'd1;
    // A command that actually changes the voice (stops always do, starts only when idle)
    assign w_cmd_eff = i_cmd_we && (i_cmd_stop || !r_busy[i_cmd_ch]);

    // Byte address of every voice, flattened for the fetcher's selector
    always_comb begin
        w_addr_flat = '0;
        for (int v = 0; v < NV; v++) begin
            w_addr_flat[v*AW +: AW] = r_na[v][AW:1];
        end
    end

    jt6295_voice_ctrl_rom_fetch #(.AW(AW)) u_fetch (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (r_busy & ~r_bv),
        .i_addr       (w_addr_flat),
        .i_rom_data   (i_rom_data),
        .i_rom_ok     (i_rom_ok),
        .o_rom_addr   (o_rom_addr),
        .o_rom_cs     (o_rom_cs),
        .o_issue      (w_issue),
        .o_issue_voice(w_issue_voice),
        .o_done       (w_done),
        .o_voice      (w_fvoice),
        .o_byte       (w_byte)
    );

    // Voice state: fetch landing, slot service, then commands (commands win)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int v = 0; v < NV; v++) begin
                r_na[v]  <= '0;
                r_end[v] <= '0;
                r_att[v] <= 4'd0;
                r_buf[v] <= 8'd0;
            end
            r_bv    <= '0;
            r_busy  <= '0;
            r_under <= '0;
            r_stale <= 1'b0;
            r_slot  <= 2'd3;
            r_out   <= '0;
        end else begin
            // Any stop/start of the in-flight voice makes its pending byte stale
            if (w_issue) begin
                r_stale <= w_cmd_eff && (i_cmd_ch == w_issue_voice);
            end else if (w_cmd_eff && (i_cmd_ch == w_fvoice)) begin
                r_stale <= 1'b1;
            end

            if (w_done && r_busy[w_fvoice] && !r_stale) begin
                r_buf[w_fvoice] <= w_byte;
                r_bv[w_fvoice]  <= 1'b1;
            end

            if (i_cen) begin
                r_slot <= w_nslot;
                if (!r_busy[w_nslot]) begin
                    r_out <= '0;
                end else if (r_bv[w_nslot]) begin
                    r_out.en   <= 1'b1;
                    r_out.att  <= r_att[w_nslot];
                    r_out.data <= r_na[w_nslot][0] ? r_buf[w_nslot][3:0] : r_buf[w_nslot][7:4];
                    r_na[w_nslot] <= r_na[w_nslot] + {{AW{1'b0}}, 1'b1};
                    if (r_na[w_nslot][0]) begin
                        r_bv[w_nslot] <= 1'b0;
                        if (r_na[w_nslot][AW:1] == r_end[w_nslot]) r_busy[w_nslot] <= 1'b0;
                    end
                end else begin
                    r_out.en          <= 1'b1;
                    r_out.att         <= r_att[w_nslot];
                    r_out.data        <= 4'd0;
                    r_under[w_nslot]  <= 1'b1;
                end
            end

            if (i_cmd_we) begin
                if (i_cmd_stop) begin
                    r_busy[i_cmd_ch] <= 1'b0;
                    r_bv[i_cmd_ch]   <= 1'b0;
                end else if (!r_busy[i_cmd_ch]) begin
                    r_na[i_cmd_ch]    <= {i_cmd_start, 1'b0};
                    r_end[i_cmd_ch]   <= i_cmd_end;
                    r_att[i_cmd_ch]   <= i_cmd_att;
                    r_bv[i_cmd_ch]    <= 1'b0;
                    r_busy[i_cmd_ch]  <= 1'b1;
                    r_under[i_cmd_ch] <= 1'b0;
                end
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_underrun   = r_under;
    assign o_adpcm_en   = r_out.en;
    assign o_adpcm_att  = r_out.att;
    assign o_adpcm_data = r_out.data;
    assign o_slot       = r_slot;

endmodule

// File: tb/tb_jt6295_voice_ctrl.sv
// tb/tb_jt6295_voice_ctrl.sv - directed self-checking bench for jt6295_voice_ctrl
module tb_jt6295_voice_ctrl;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst, cen, cmd_we, cmd_stop;
    logic [1:0]    cmd_ch;
    logic [AW-1:0] cmd_start, cmd_end;
    logic [3:0]    cmd_att;
    logic [3:0]    busy, underrun;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic          adpcm_en;
    logic [3:0]    adpcm_att, adpcm_data;
    logic [1:0]    slot;

    always #5 clk = ~clk;

    jt6295_voice_ctrl #(.AW(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_cen(cen),
        .i_cmd_we(cmd_we), .i_cmd_stop(cmd_stop), .i_cmd_ch(cmd_ch),
        .i_cmd_start(cmd_start), .i_cmd_end(cmd_end), .i_cmd_att(cmd_att),
        .o_busy(busy), .o_underrun(underrun),
        .o_rom_addr(rom_addr), .o_rom_cs(rom_cs), .i_rom_data(rom_data), .i_rom_ok(rom_ok),
        .o_adpcm_en(adpcm_en), .o_adpcm_att(adpcm_att), .o_adpcm_data(adpcm_data), .o_slot(slot)
    );

    // ROM model: ok arrives lat clocks after cs rises; data is junk on the first cs clock
    int lat = 2;
    bit force_ok = 1'b0;
    int cnt = 0;

    always @(posedge clk) begin
        if (!rom_cs) cnt <= 0;
        else         cnt <= cnt + 1;
    end

    function automatic logic [7:0] romv(input logic [AW-1:0] a);
        case (a)
            18'h00100: romv = 8'h7A;
            18'h00101: romv = 8'h3C;
            default:   romv = {a[11:8], a[3:0]};
        endcase
    endfunction

    assign rom_data = (rom_cs && cnt >= 1) ? romv(rom_addr) : 8'hEE;
    assign rom_ok   = force_ok || (rom_cs && cnt >= lat - 1);

    int vectors = 0;
    int errs    = 0;
    int per     = 8;
    int phase   = 0;
    bit last_cen = 1'b0;
    bit cs_prev  = 1'b0;

    logic       h_en   [4][16];
    logic [3:0] h_att  [4][16];
    logic [3:0] h_data [4][16];
    int         h_n    [4];
    logic [AW-1:0] f_log [16];
    int         f_n;
    logic [1:0] s_log  [16];
    int         s_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        for (int v = 0; v < 4; v++) begin
            h_n[v] = 0;
            for (int k = 0; k < 16; k++) begin
                h_en[v][k] = 1'bx; h_att[v][k] = 4'hx; h_data[v][k] = 4'hx;
            end
        end
        f_n = 0;
        s_n = 0;
    endtask

    task automatic tick();
        int v;
        cen = (phase == 0);
        @(posedge clk);
        #1;
        phase    = (phase + 1) % per;
        last_cen = cen;
        if (cen) begin
            v = int'(slot);
            if (h_n[v] < 16) begin
                h_en[v][h_n[v]]   = adpcm_en;
                h_att[v][h_n[v]]  = adpcm_att;
                h_data[v][h_n[v]] = adpcm_data;
            end
            h_n[v]++;
            if (s_n < 16) s_log[s_n] = slot;
            s_n++;
        end
        if (rom_cs && !cs_prev) begin
            if (f_n < 16) f_log[f_n] = rom_addr;
            f_n++;
        end
        cs_prev = rom_cs;
    endtask

    task automatic set_per(input int p);
        per   = p;
        phase = 0;
    endtask

    task automatic cmd(input logic stop, input logic [1:0] ch, input logic [AW-1:0] st,
                       input logic [AW-1:0] en, input logic [3:0] att);
        cmd_we = 1'b1; cmd_stop = stop; cmd_ch = ch; cmd_start = st; cmd_end = en; cmd_att = att;
        tick();
        cmd_we = 1'b0;
    endtask

    task automatic wait_slot3();
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(last_cen && slot == 2'd3) && k < 64);
        chk("wait_slot3", {31'd0, last_cen && slot == 2'd3}, 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy != 4'd0 || rom_cs) && k < 400) begin
            tick();
            k++;
        end
        chk("wait_idle", {27'd0, busy, rom_cs}, 32'd0);
    endtask

    task automatic run_slots(input int v, input int n);
        int k = 0;
        while (h_n[v] < n && k < 600) begin
            tick();
            k++;
        end
        chk("run_slots", {31'd0, h_n[v] >= n}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, {28'd0, busy}, 32'd0);
        chk({tag, "_under"}, {28'd0, underrun}, 32'd0);
        chk({tag, "_cs"}, {31'd0, rom_cs}, 32'd0);
        chk({tag, "_addr"}, {14'd0, rom_addr}, 32'd0);
        chk({tag, "_en"}, {31'd0, adpcm_en}, 32'd0);
        chk({tag, "_att"}, {28'd0, adpcm_att}, 32'd0);
        chk({tag, "_data"}, {28'd0, adpcm_data}, 32'd0);
        chk({tag, "_slot"}, {30'd0, slot}, 32'd3);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; cmd_we = 1'b0; cmd_stop = 1'b0; cmd_ch = 2'd0;
        cmd_start = '0; cmd_end = '0; cmd_att = 4'd0;
        clear_logs();

        // Reset state, then first cen presents voice 0
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;
        set_per(8);
        tick();
        chk("first_slot", {30'd0, slot}, 32'd0);
        chk("first_en", {31'd0, adpcm_en}, 32'd0);

        // 1: single voice, two bytes 7A 3C
        lat = 2;
        wait_slot3();
        clear_logs();
        cmd(1'b0, 2'd0, 18'h00100, 18'h00101, 4'd5);
        run_slots(0, 5);
        chk("t1_d0", {28'd0, h_data[0][0]}, 32'h7);
        chk("t1_d1", {28'd0, h_data[0][1]}, 32'hA);
        chk("t1_d2", {28'd0, h_data[0][2]}, 32'h3);
        chk("t1_d3", {28'd0, h_data[0][3]}, 32'hC);
        chk("t1_en", {27'd0, h_en[0][0], h_en[0][1], h_en[0][2], h_en[0][3], h_en[0][4]}, 32'b11110);
        chk("t1_d4", {28'd0, h_data[0][4]}, 32'h0);
        chk("t1_att", {28'd0, h_att[0][0]}, 32'h5);
        chk("t1_v1_en", {31'd0, h_en[1][0]}, 32'd0);
        chk("t1_busy", {28'd0, busy}, 32'd0);
        chk("t1_under", {28'd0, underrun}, 32'd0);
        chk("t1_f0", {14'd0, f_log[0]}, 32'h100);
        chk("t1_f1", {14'd0, f_log[1]}, 32'h101);

        // 2: all four voices, latency 3, cen every 8
        lat = 3;
        wait_idle();
        wait_slot3();
        clear_logs();
        cmd(1'b0, 2'd0, 18'h00200, 18'h00201, 4'd1);
        cmd(1'b0, 2'd1, 18'h00300, 18'h00301, 4'd2);
        cmd(1'b0, 2'd2, 18'h00400, 18'h00401, 4'd3);
        cmd(1'b0, 2'd3, 18'h00500, 18'h00501, 4'd4);
        run_slots(3, 5);
        chk("t2_under", {28'd0, underrun}, 32'd0);
        chk("t2_f0", {14'd0, f_log[0]}, 32'h200);
        chk("t2_f1", {14'd0, f_log[1]}, 32'h300);
        chk("t2_f2", {14'd0, f_log[2]}, 32'h400);
        chk("t2_f3", {14'd0, f_log[3]}, 32'h500);
        chk("t2_f4", {14'd0, f_log[4]}, 32'h201);
        chk("t2_slots", {16'd0, s_log[0], s_log[1], s_log[2], s_log[3], s_log[4], s_log[5], s_log[6], s_log[7]},
            32'b0001_1011_0001_1011);
        chk("t2_v2_data", {16'd0, h_data[2][0], h_data[2][1], h_data[2][2], h_data[2][3]}, 32'h4041);
        chk("t2_v2_en4", {31'd0, h_en[2][4]}, 32'd0);
        chk("t2_v3_att", {28'd0, h_att[3][0]}, 32'h4);

        // 3: ok held high, first WAIT clock must be ignored
        wait_idle();
        force_ok = 1'b1;
        wait_slot3();
        clear_logs();
        cmd(1'b0, 2'd1, 18'h00600, 18'h00600, 4'd7);
        run_slots(1, 3);
        force_ok = 1'b0;
        chk("t3_data", {24'd0, h_data[1][0], h_data[1][1]}, 32'h60);
        chk("t3_en", {29'd0, h_en[1][0], h_en[1][1], h_en[1][2]}, 32'b110);
        chk("t3_under", {28'd0, underrun}, 32'd0);

        // 4: stop v2 while its fetch waits; byte dropped, v3 served next
        lat = 10;
        wait_idle();
        wait_slot3();
        clear_logs();
        cmd(1'b0, 2'd2, 18'h00700, 18'h00701, 4'd2);
        cmd(1'b0, 2'd3, 18'h00800, 18'h00800, 4'd6);
        tick();
        chk("t4_cs_pre", {31'd0, rom_cs}, 32'd1);
        chk("t4_addr_pre", {14'd0, rom_addr}, 32'h700);
        cmd(1'b1, 2'd2, 18'h0, 18'h0, 4'd0);
        run_slots(3, 3);
        chk("t4_f1", {14'd0, f_log[1]}, 32'h800);
        chk("t4_fn", f_n, 32'd2);
        chk("t4_v2_en", {31'd0, h_en[2][0]}, 32'd0);
        chk("t4_v3_data", {24'd0, h_data[3][0], h_data[3][1]}, 32'h80);
        chk("t4_v3_en", {29'd0, h_en[3][0], h_en[3][1], h_en[3][2]}, 32'b110);
        chk("t4_busy", {28'd0, busy}, 32'd0);
        chk("t4_under", {28'd0, underrun}, 32'd0);

        // 5: slow ROM, fast cen -> underrun with en=1 data=0, restart clears it
        lat = 40;
        wait_idle();
        set_per(4);
        wait_slot3();
        clear_logs();
        cmd(1'b0, 2'd0, 18'h00900, 18'h00900, 4'd9);
        run_slots(0, 6);
        chk("t5_u_en", {31'd0, h_en[0][0]}, 32'd1);
        chk("t5_u_data", {28'd0, h_data[0][0]}, 32'd0);
        chk("t5_u_att", {28'd0, h_att[0][0]}, 32'h9);
        chk("t5_u2", {27'd0, h_en[0][2], h_data[0][2]}, 32'h10);
        chk("t5_hi", {27'd0, h_en[0][3], h_data[0][3]}, 32'h19);
        chk("t5_lo", {27'd0, h_en[0][4], h_data[0][4]}, 32'h10);
        chk("t5_off", {31'd0, h_en[0][5]}, 32'd0);
        chk("t5_sticky", {28'd0, underrun}, 32'b0001);
        cmd(1'b0, 2'd0, 18'h00900, 18'h00900, 4'd9);
        chk("t5_clear", {28'd0, underrun}, 32'd0);
        chk("t5_busy", {28'd0, busy}, 32'b0001);
        repeat (16) tick();
        chk("t5_again", {28'd0, underrun}, 32'b0001);
        cmd(1'b1, 2'd0, 18'h0, 18'h0, 4'd0);
        chk("t5_stop", {28'd0, busy}, 32'd0);

        // 6: start to a busy voice ignored, then reset mid-playback and mid-fetch
        lat = 2;
        set_per(8);
        wait_idle();
        wait_slot3();
        clear_logs();
        cmd(1'b0, 2'd1, 18'h00A00, 18'h00A01, 4'd3);
        cmd(1'b0, 2'd1, 18'h00B00, 18'h00B01, 4'hC);
        run_slots(1, 2);
        chk("t6_att", {24'd0, h_att[1][0], h_att[1][1]}, 32'h33);
        chk("t6_data", {24'd0, h_data[1][0], h_data[1][1]}, 32'hA0);
        chk("t6_f0", {14'd0, f_log[0]}, 32'hA00);
        chk("t6_under", {28'd0, underrun}, 32'b0001);
        lat = 40;
        cmd(1'b0, 2'd3, 18'h00C00, 18'h00C00, 4'd1);
        tick(); tick(); tick();
        chk("t6_cs_pre", {31'd0, rom_cs}, 32'd1);
        chk("t6_busy_pre", {28'd0, busy}, 32'b1010);
        rst = 1'b1;
        tick();
        chk_reset("t6_rst");
        rst = 1'b0;
        lat = 2;
        repeat (12) tick();
        chk("t6_post_busy", {28'd0, busy}, 32'd0);
        chk("t6_post_en", {31'd0, adpcm_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
